mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
Single-port memory controller and arbiter sharing the byte-wide RAM between instruction fetch (IF) and the MEM stage.
- Serialises each 32/16/8-bit request into byte accesses.
- Assembles and sign-/zero-extends load data.
- Drives the stall lines (stl_if, stl_mm) that freeze the pipeline registers, including the EX/MEM register, until the transaction completes.

Parameters:
ADDR_W, 32, width of all address ports
RAM_LAT, 1, RAM read latency in cycles; only the value 1 is supported, anything else is a fatal elaboration error

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch request, held level until if_done
if_addr  in  ADDR_W  fetch address; always a word access
if_flush  in  1  branch redirect; aborts or suppresses the current fetch
if_done  out  1  one-cycle pulse; if_inst valid in the same cycle
if_inst  out  32  fetched instruction
mm_req  in  1  MEM-stage request, held until mm_done
mm_op  in  5  MEM op: [4] valid, [3] write, [2] unsigned, [1:0] size (0=byte, 1=half, 2=word)
mm_addr  in  ADDR_W  data address
mm_wdata  in  32  store data
mm_done  out  1  one-cycle pulse; mm_rdata valid in the same cycle
mm_rdata  out  32  extended load data
ram_addr  out  ADDR_W  RAM byte address
ram_dout  out  8  RAM write byte
ram_wr  out  1  RAM write enable
ram_din  in  8  RAM read byte, returned 1 cycle after ram_addr
stl_if  out  1  combinational: if_req & ~if_done
stl_mm  out  1  combinational: mm_req & mm_op[4] & ~mm_done

Behaviour:
- States:
  - IDLE: arbitrate and issue byte 0.
  - RD: issue next address and capture returned byte.
  - WR: write next byte.
  - DONE: pulse done, no arbitration.
- Reset: state IDLE, cnt 0, if_done/mm_done 0, if_inst/mm_rdata 0, ram_wr 0, ram_addr 0, ram_dout 0. rst mid-transaction abandons it immediately; a partial write is not completed.
- Arbitration (IDLE only):
  - MEM wins if mm_req & mm_op[4].
  - Otherwise IF wins if if_req & ~if_flush.
  - A granted transaction is never preempted.
- Byte count N is 1/2/4 from size; IF is always N=4. Little-endian.
  - Byte k goes to addr+k; the address adder wraps modulo 2^ADDR_W.
  - size=3 is treated as word.
- Read timeline (grant cycle T):
  - Cycle T+k, k<N: ram_addr = addr+k.
  - Cycle T+k+1: capture ram_din into byte lane k.
  - DONE at T+N+1; word read done at T+5, byte read at T+2.
- Write timeline:
  - Cycle T+k: ram_addr = addr+k, ram_wr=1, ram_dout = wdata[8k+7:8k].
  - DONE at T+N; word write done at T+4.
- Extension: op[2]=0 sign-extends from bit 8N-1; op[2]=1 zero-extends.
- DONE lasts exactly one cycle, then IDLE. Requesters change or drop req in the cycle after done, so back-to-back transactions incur one idle cycle.
- if_flush during an IF read (IDLE grant cycle, RD or DONE):
  - Abandon the read; next state IDLE.
  - if_done is suppressed; if_inst is not updated.
- MEM transactions ignore if_flush.
- ram_wr is 0 in every cycle not in WR or the write-grant cycle.
- mm_req with mm_op[4]=0 is ignored; stl_mm stays 0.

Decomposition:
- Shared package mem_pkg:
  - mm_op field indices.
  - Size encodings SZ_B/SZ_H/SZ_W.
  - State encodings S_IDLE/S_RD/S_WR/S_DONE.
  - Requester IDs OWN_IF/OWN_MM.
- One sub-module, mem_load_ext: combinational byte-lane assembly, sign/zero extension by size and unsigned flag.

Test Plan:
- Word fetch at if_addr 0x100, RAM bytes 13 00 00 00 -> ram_addr 0x100..0x103 at T..T+3; if_done and if_inst=0x00000013 at T+5; stl_if high T..T+4.
- if_req and mm_req (LW 0x200) in the same cycle -> MEM granted first, mm_done at T+5; fetch granted at T+6, if_done at T+11.
- LB at 0x300 holding 0x80 -> mm_rdata=0xFFFFFF80 at T+2; LBU -> 0x00000080; LH of 0x80,0xFF -> 0xFFFFFF80.
- SW 0xDEADBEEF at 0x400 -> ram_wr=1 with EF,BE,AD,DE at 0x400..0x403 in cycles T..T+3; mm_done at T+4, ram_wr=0 at T+4.
- if_flush at T+2 of a fetch -> IDLE at T+3, no if_done; new fetch at the redirected address granted at T+3.
- rst at T+1 of SW -> only byte 0 written; all outputs at reset values next cycle; no mm_done.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serialising memory controller.
package mem_pkg;

    // mm_op field positions
    localparam int OP_VALID = 4;
    localparam int OP_WRITE = 3;
    localparam int OP_UNS   = 2;
    localparam int OP_SZ_HI = 1;
    localparam int OP_SZ_LO = 0;

    // access size encodings (3 is treated as word)
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MM = 1'b1
    } owner_t;

    // number of byte beats for a size code
    function automatic logic [2:0] nbytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    nbytes = 3'd1;
            SZ_H:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data formatting: picks the valid low lanes and sign/zero extends.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] lanes,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    // extend from the top bit of the accessed width
    always_comb begin
        data = lanes;
        case (size)
            SZ_B:    data = uns ? {24'd0, lanes[7:0]}  : {{24{lanes[7]}}, lanes[7:0]};
            SZ_H:    data = uns ? {16'd0, lanes[15:0]} : {{16{lanes[15]}}, lanes[15:0]};
            default: data = lanes;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port byte RAM controller arbitrating between fetch and MEM stage.
//
// state  | meaning
// S_IDLE | arbitrate; the grant cycle also issues byte 0
// S_RD   | issue next read address, capture byte returned for previous one
// S_WR   | write next byte of the store
// S_DONE | one-cycle done pulse, no arbitration
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mm_req,
    input  logic [4:0]        mm_op,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic [31:0]       mm_wdata,
    output logic              mm_done,
    output logic [31:0]       mm_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic              stl_if,
    output logic              stl_mm
);

    generate
        if (RAM_LAT != 1) begin : g_lat_check
            $fatal(1, "mem_ctrl: only RAM_LAT = 1 is supported");
        end
    endgenerate

    state_t            state, state_n;
    owner_t            owner, owner_n;
    logic [2:0]        cnt, cnt_n;
    logic [2:0]        nb, nb_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [1:0]        size_q, size_n;
    logic              uns_q, uns_n;
    logic [31:0]       lane_q, lane_n;
    logic [31:0]       if_inst_q;
    logic [31:0]       mm_rdata_q;
    logic [31:0]       ext_data;

    mem_load_ext u_ext (
        .lanes (lane_q),
        .size  (size_q),
        .uns   (uns_q),
        .data  (ext_data)
    );

    // state and transaction context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_IF;
            cnt        <= 3'd0;
            nb         <= 3'd0;
            base       <= '0;
            wdata_q    <= 32'd0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            lane_q     <= 32'd0;
            if_inst_q  <= 32'd0;
            mm_rdata_q <= 32'd0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            cnt     <= cnt_n;
            nb      <= nb_n;
            base    <= base_n;
            wdata_q <= wdata_n;
            size_q  <= size_n;
            uns_q   <= uns_n;
            lane_q  <= lane_n;
            if (if_done) if_inst_q  <= lane_q;
            if (mm_done) mm_rdata_q <= ext_data;
        end
    end

    // next-state, RAM strobes and done pulses
    always_comb begin
        state_n  = state;
        owner_n  = owner;
        cnt_n    = cnt;
        nb_n     = nb;
        base_n   = base;
        wdata_n  = wdata_q;
        size_n   = size_q;
        uns_n    = uns_q;
        lane_n   = lane_q;
        ram_addr = '0;
        ram_dout = 8'd0;
        ram_wr   = 1'b0;
        if_done  = 1'b0;
        mm_done  = 1'b0;

        case (state)
            S_IDLE: begin
                if (mm_req && mm_op[OP_VALID]) begin
                    owner_n  = OWN_MM;
                    base_n   = mm_addr;
                    nb_n     = nbytes(mm_op[OP_SZ_HI:OP_SZ_LO]);
                    size_n   = mm_op[OP_SZ_HI:OP_SZ_LO];
                    uns_n    = mm_op[OP_UNS];
                    wdata_n  = mm_wdata;
                    cnt_n    = 3'd1;
                    lane_n   = 32'd0;
                    ram_addr = mm_addr;
                    if (mm_op[OP_WRITE]) begin
                        ram_wr   = 1'b1;
                        ram_dout = mm_wdata[7:0];
                        state_n  = (nbytes(mm_op[OP_SZ_HI:OP_SZ_LO]) == 3'd1) ? S_DONE : S_WR;
                    end else begin
                        state_n  = S_RD;
                    end
                end else if (if_req && !if_flush) begin
                    owner_n  = OWN_IF;
                    base_n   = if_addr;
                    nb_n     = 3'd4;
                    size_n   = SZ_W;
                    uns_n    = 1'b1;
                    cnt_n    = 3'd1;
                    lane_n   = 32'd0;
                    ram_addr = if_addr;
                    state_n  = S_RD;
                end
            end
            S_RD: begin
                // RAM returns the byte addressed in the previous cycle
                case (cnt)
                    3'd1:    lane_n[7:0]   = ram_din;
                    3'd2:    lane_n[15:8]  = ram_din;
                    3'd3:    lane_n[23:16] = ram_din;
                    3'd4:    lane_n[31:24] = ram_din;
                    default: ;
                endcase
                if (cnt < nb) ram_addr = base + ADDR_W'(cnt);
                cnt_n = cnt + 3'd1;
                if (cnt == nb) state_n = S_DONE;
                if (owner == OWN_IF && if_flush) state_n = S_IDLE;
            end
            S_WR: begin
                ram_wr   = 1'b1;
                ram_addr = base + ADDR_W'(cnt);
                case (cnt[1:0])
                    2'd0:    ram_dout = wdata_q[7:0];
                    2'd1:    ram_dout = wdata_q[15:8];
                    2'd2:    ram_dout = wdata_q[23:16];
                    default: ram_dout = wdata_q[31:24];
                endcase
                cnt_n = cnt + 3'd1;
                if (cnt == nb - 3'd1) state_n = S_DONE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 3'd0;
                if (owner == OWN_MM) mm_done = 1'b1;
                else if (!if_flush)  if_done = 1'b1;
            end
        endcase

        // reset abandons the transaction in the cycle it is asserted
        if (rst) begin
            ram_addr = '0;
            ram_dout = 8'd0;
            ram_wr   = 1'b0;
            if_done  = 1'b0;
            mm_done  = 1'b0;
        end
    end

    assign if_inst  = if_done ? lane_q   : if_inst_q;
    assign mm_rdata = mm_done ? ext_data : mm_rdata_q;
    assign stl_if   = if_req & ~if_done;
    assign stl_mm   = mm_req & mm_op[OP_VALID] & ~mm_done;

endmodule
